// File: rtl/hdmi_fetch_pkg.sv
// Shared definitions for the HDMI scan-out read scheduler: FSM encoding,
// AXI burst constants and beat geometry.
package hdmi_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FETCH   = 2'd2,
        ST_DRAIN   = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned BEAT_BYTES = 64;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;

    // Beats left before the next 4 KB page, from the in-page byte offset.
    function automatic logic [8:0] beats_to_page(input logic [11:0] page_offset);
        return 9'(PAGE_BEATS) - 9'(page_offset[11:BEAT_SHIFT]);
    endfunction

endpackage

// File: rtl/hdmi_fetch_credit.sv
// Downstream FIFO credit and in-flight AR burst counters; o_can_issue answers
// whether a burst of i_beats may be requested right now.
module hdmi_fetch_credit
    import hdmi_fetch_pkg::*;
#(
    parameter int C_FIFO_DEPTH      = 64,
    parameter int C_MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] i_beats,
    input  logic       i_ar_hs,
    input  logic       i_r_last,
    input  logic       i_pop,
    output logic       o_can_issue,
    output logic       o_idle
);

    localparam int CW = $clog2(C_FIFO_DEPTH + 1);
    localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

    logic [CW-1:0] r_credits;
    logic [OW-1:0] r_outstanding;
    logic [CW-1:0] w_credits_next;
    logic          w_pop_eff;

    assign o_can_issue = (32'(r_credits) >= 32'(i_beats)) &&
                         (32'(r_outstanding) < C_MAX_OUTSTANDING);
    assign o_idle      = (r_outstanding == '0);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_pop_eff      = i_pop && (32'(r_credits) != C_FIFO_DEPTH);
        w_credits_next = r_credits;
        if (i_ar_hs)
            w_credits_next = w_credits_next - CW'(i_beats);
        if (w_pop_eff)
            w_credits_next = w_credits_next + CW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits     <= CW'(C_FIFO_DEPTH);
            r_outstanding <= '0;
        end else begin
            r_credits <= w_credits_next;
            if (i_ar_hs && !i_r_last)
                r_outstanding <= r_outstanding + OW'(1);
            else if (!i_ar_hs && i_r_last && r_outstanding != '0)
                r_outstanding <= r_outstanding - OW'(1);
        end
    end

endmodule

// File: rtl/hdmi_fetch_scheduler.sv
// Frame fetch scheduler: walks a framebuffer line by line issuing 4 KB-safe
// AXI read bursts under FIFO credit control. Define HDMI_FETCH_PERF_EN for the stall counter.
module hdmi_fetch_scheduler
    import hdmi_fetch_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_FIFO_DEPTH       = 64,
    parameter int C_MAX_OUTSTANDING  = 4,
    parameter int C_MAX_BURST        = 16
) (
    input  logic                          ACLK,
    input  logic                          nRST,
    input  logic                          CFG_EN,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] CFG_BASE,
    input  logic [15:0]                   CFG_STRIDE,
    input  logic [8:0]                    CFG_LINE_BEATS,
    input  logic [11:0]                   CFG_LINES,
    input  logic                          VSYNC_START,
    input  logic                          FIFO_POP,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_ARADDR,
    output logic [7:0]                    M_ARLEN,
    output logic [2:0]                    M_ARSIZE,
    output logic [1:0]                    M_ARBURST,
    output logic                          M_ARVALID,
    input  logic                          M_ARREADY,
    input  logic                          M_RVALID,
    input  logic                          M_RREADY,
    input  logic                          M_RLAST,
    output logic                          BUSY,
    output logic                          FRAME_DONE,
    output logic                          LATE,
    output logic [31:0]                   PERF_STALL
);

    localparam int         AW          = C_M_AXI_ADDR_WIDTH;
    localparam logic [2:0] L_ARSIZE    = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    localparam logic [8:0] L_MAX_BURST = 9'(C_MAX_BURST);

    fetch_state_t  r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_line_start;
    logic [AW-1:0] r_araddr;
    logic [15:0]   r_stride;
    logic [8:0]    r_line_beats;
    logic [8:0]    r_remaining;
    logic [8:0]    r_beats;
    logic [11:0]   r_lines;
    logic [11:0]   r_line;
    logic [7:0]    r_arlen;
    logic          r_arvalid;
    logic          r_late;

    logic [8:0]    w_page_beats;
    logic [8:0]    w_beats;
    logic [8:0]    w_credit_beats;
    logic [8:0]    w_rem_after;
    logic [AW-1:0] w_addr_step;
    logic          w_ar_hs;
    logic          w_r_last;
    logic          w_can_issue;
    logic          w_out_idle;
    logic          w_last_line;
    logic          w_issue;
    logic          w_frame_start;

    always_comb begin
        w_page_beats = beats_to_page(r_addr[11:0]);
        w_beats      = r_remaining;
        if (L_MAX_BURST < w_beats)
            w_beats = L_MAX_BURST;
        if (w_page_beats < w_beats)
            w_beats = w_page_beats;
    end

    // The counters see the held burst size while a request is pending, else the candidate.
    assign w_credit_beats = r_arvalid ? r_beats : w_beats;
    assign w_ar_hs        = r_arvalid && M_ARREADY;
    assign w_r_last       = M_RVALID && M_RREADY && M_RLAST;
    assign w_rem_after    = r_remaining - r_beats;
    assign w_addr_step    = AW'(r_beats) << BEAT_SHIFT;
    assign w_last_line    = (r_line + 12'd1) == r_lines;
    assign w_issue        = (r_state == ST_FETCH) && !r_arvalid && CFG_EN && w_can_issue;
    assign w_frame_start  = (r_state == ST_WAIT_VS) && CFG_EN && VSYNC_START;

    hdmi_fetch_credit #(
        .C_FIFO_DEPTH      (C_FIFO_DEPTH),
        .C_MAX_OUTSTANDING (C_MAX_OUTSTANDING)
    ) u_credit (
        .clk         (ACLK),
        .rst_n       (nRST),
        .i_beats     (w_credit_beats),
        .i_ar_hs     (w_ar_hs),
        .i_r_last    (w_r_last),
        .i_pop       (FIFO_POP),
        .o_can_issue (w_can_issue),
        .o_idle      (w_out_idle)
    );

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_line_start <= '0;
            r_araddr     <= '0;
            r_stride     <= '0;
            r_line_beats <= '0;
            r_remaining  <= '0;
            r_beats      <= '0;
            r_lines      <= '0;
            r_line       <= '0;
            r_arlen      <= '0;
            r_arvalid    <= 1'b0;
            r_late       <= 1'b0;
        end else begin
            r_late <= VSYNC_START && (r_state == ST_FETCH || r_state == ST_DRAIN);
            case (r_state)
                ST_IDLE: begin
                    if (CFG_EN)
                        r_state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (!CFG_EN) begin
                        r_state <= ST_IDLE;
                    end else if (w_frame_start) begin
                        r_stride     <= CFG_STRIDE;
                        r_line_beats <= CFG_LINE_BEATS;
                        r_lines      <= CFG_LINES;
                        r_line_start <= CFG_BASE;
                        r_addr       <= CFG_BASE;
                        r_remaining  <= CFG_LINE_BEATS;
                        r_line       <= '0;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A raised request is held untouched until accepted, whatever CFG_EN does.
                    if (w_issue) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_addr;
                        r_arlen   <= 8'(w_beats - 9'd1);
                        r_beats   <= w_beats;
                    end else if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        if (w_rem_after != '0) begin
                            r_addr      <= r_addr + w_addr_step;
                            r_remaining <= w_rem_after;
                        end else begin
                            r_line       <= r_line + 12'd1;
                            r_line_start <= r_line_start + AW'(r_stride);
                            r_addr       <= r_line_start + AW'(r_stride);
                            r_remaining  <= r_line_beats;
                        end
                        if ((w_rem_after == '0 && w_last_line) || !CFG_EN)
                            r_state <= ST_DRAIN;
                    end else if (!r_arvalid && !CFG_EN) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_out_idle)
                        r_state <= CFG_EN ? ST_WAIT_VS : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign M_ARID     = '0;
    assign M_ARADDR   = r_araddr;
    assign M_ARLEN    = r_arlen;
    assign M_ARSIZE   = L_ARSIZE;
    assign M_ARBURST  = BURST_INCR;
    assign M_ARVALID  = r_arvalid;
    assign BUSY       = (r_state != ST_IDLE);
    assign FRAME_DONE = (r_state == ST_DRAIN) && w_out_idle && CFG_EN;
    assign LATE       = r_late;

`ifdef HDMI_FETCH_PERF_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge ACLK or negedge nRST) begin
        if (!nRST)
            r_perf_stall <= '0;
        else if (w_frame_start)
            r_perf_stall <= '0;
        else if (r_state == ST_FETCH && !r_arvalid && CFG_EN && !w_can_issue &&
                 r_perf_stall != '1)
            r_perf_stall <= r_perf_stall + 32'd1;
    end

    assign PERF_STALL = r_perf_stall;
`else
    assign PERF_STALL = '0;
`endif

endmodule

// File: tb/tb_hdmi_fetch_scheduler.sv
// Scoreboard bench for hdmi_fetch_scheduler: a reference burst model fills the
// expected-AR queue, each AR handshake pops and compares it.
`timescale 1ns/1ps
module tb_hdmi_fetch_scheduler;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        ACLK = 1'b0;
    logic        nRST;
    logic        CFG_EN;
    logic [31:0] CFG_BASE;
    logic [15:0] CFG_STRIDE;
    logic [8:0]  CFG_LINE_BEATS;
    logic [11:0] CFG_LINES;
    logic        VSYNC_START;
    logic        FIFO_POP;
    logic [1:0]  M_ARID;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic        M_RVALID;
    logic        M_RREADY;
    logic        M_RLAST;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        LATE;
    logic [31:0] PERF_STALL;

    ar_t         sb[$];
    int          n_total;
    int          n_bad;
    int          ar_cnt;
    int          r_cnt;
    int          done_cnt;
    int          late_cnt;
    int          pops_left;
    bit          pop_always;
    bit          resp_en;
    bit          prev_valid;
    bit          prev_ready;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    always #5 ACLK = ~ACLK;

    hdmi_fetch_scheduler dut (
        .ACLK           (ACLK),
        .nRST           (nRST),
        .CFG_EN         (CFG_EN),
        .CFG_BASE       (CFG_BASE),
        .CFG_STRIDE     (CFG_STRIDE),
        .CFG_LINE_BEATS (CFG_LINE_BEATS),
        .CFG_LINES      (CFG_LINES),
        .VSYNC_START    (VSYNC_START),
        .FIFO_POP       (FIFO_POP),
        .M_ARID         (M_ARID),
        .M_ARADDR       (M_ARADDR),
        .M_ARLEN        (M_ARLEN),
        .M_ARSIZE       (M_ARSIZE),
        .M_ARBURST      (M_ARBURST),
        .M_ARVALID      (M_ARVALID),
        .M_ARREADY      (M_ARREADY),
        .M_RVALID       (M_RVALID),
        .M_RREADY       (M_RREADY),
        .M_RLAST        (M_RLAST),
        .BUSY           (BUSY),
        .FRAME_DONE     (FRAME_DONE),
        .LATE           (LATE),
        .PERF_STALL     (PERF_STALL)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: split each line into bursts of at most 16 beats that stay inside a 4 KB page.
    task automatic push_frame(input logic [31:0] base, input logic [15:0] stride,
                              input int lb, input int lines);
        logic [31:0] ls;
        logic [31:0] a;
        int          rem;
        int          b;
        int          pg;
        ar_t         e;
        ls = base;
        for (int l = 0; l < lines; l++) begin
            a   = ls;
            rem = lb;
            while (rem > 0) begin
                pg = (4096 - int'(a % 32'd4096)) / 64;
                b  = rem;
                if (b > 16) b = 16;
                if (b > pg) b = pg;
                e.addr = a;
                e.len  = 8'(b - 1);
                sb.push_back(e);
                a   = a + 32'(b * 64);
                rem = rem - b;
            end
            ls = ls + 32'(stride);
        end
    endtask

    task automatic sample();
        ar_t e;
        if (M_ARVALID && M_ARREADY) begin
            ar_cnt++;
            if (sb.size() == 0) begin
                check("ar_unexpected", 64'(sb.size()), 64'(1));
            end else begin
                e = sb.pop_front();
                check("araddr", 64'(M_ARADDR), 64'(e.addr));
                check("arlen", 64'(M_ARLEN), 64'(e.len));
                check("arattr", 64'({M_ARID, M_ARSIZE, M_ARBURST}), 64'({2'b00, 3'd6, 2'b01}));
            end
        end
        if (prev_valid && !prev_ready)
            check("ar_hold", 64'({M_ARVALID, M_ARADDR, M_ARLEN}), 64'({1'b1, prev_addr, prev_len}));
        prev_valid = M_ARVALID;
        prev_ready = M_ARREADY;
        prev_addr  = M_ARADDR;
        prev_len   = M_ARLEN;
        if (FRAME_DONE) done_cnt++;
        if (LATE) late_cnt++;
    endtask

    task automatic drive_bg();
        if (resp_en && !M_RLAST && r_cnt < ar_cnt) begin
            M_RVALID = 1'b1;
            M_RREADY = 1'b1;
            M_RLAST  = 1'b1;
            r_cnt++;
        end else begin
            M_RVALID = 1'b0;
            M_RREADY = 1'b0;
            M_RLAST  = 1'b0;
        end
        if (pop_always) begin
            FIFO_POP = 1'b1;
        end else if (pops_left > 0) begin
            FIFO_POP = 1'b1;
            pops_left--;
        end else begin
            FIFO_POP = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        sample();
        @(posedge ACLK);
        #1;
        drive_bg();
    endtask

    task automatic clear_tracking();
        sb.delete();
        ar_cnt     = 0;
        r_cnt      = 0;
        done_cnt   = 0;
        late_cnt   = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
    endtask

    task automatic do_reset();
        nRST        = 1'b0;
        CFG_EN      = 1'b0;
        VSYNC_START = 1'b0;
        M_ARREADY   = 1'b1;
        M_RVALID    = 1'b0;
        M_RREADY    = 1'b0;
        M_RLAST     = 1'b0;
        FIFO_POP    = 1'b0;
        pop_always  = 1'b0;
        pops_left   = 0;
        resp_en     = 1'b1;
        clear_tracking();
        repeat (2) @(posedge ACLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                               input int lb, input int lines);
        CFG_BASE       = base;
        CFG_STRIDE     = stride;
        CFG_LINE_BEATS = 9'(lb);
        CFG_LINES      = 12'(lines);
        push_frame(base, stride, lb, lines);
        CFG_EN = 1'b1;
        tick();
        tick();
        VSYNC_START = 1'b1;
        tick();
        VSYNC_START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(done_cnt), 64'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (BUSY && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(BUSY), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_total        = 0;
        n_bad          = 0;
        CFG_BASE       = '0;
        CFG_STRIDE     = '0;
        CFG_LINE_BEATS = '0;
        CFG_LINES      = '0;

        do_reset();
        tick();
        check("rst_arvalid", 64'(M_ARVALID), 64'(0));
        check("rst_araddr", 64'(M_ARADDR), 64'(0));
        check("rst_arlen", 64'(M_ARLEN), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_done_late", 64'({FRAME_DONE, LATE}), 64'(0));
        check("rst_perf", 64'(PERF_STALL), 64'(0));

        // Two 80-beat lines, unlimited pops: five 16-beat bursts per line.
        pop_always = 1'b1;
        start_frame(32'h1000, 16'h1400, 80, 2);
        check("s1_busy_fetch", 64'(BUSY), 64'(1));
        wait_done("s1_frame_done", 1, 2000);
        check("s1_ar_count", 64'(ar_cnt), 64'(10));
        check("s1_sb_empty", 64'(sb.size()), 64'(0));
        check("s1_wait_vs_busy", 64'(BUSY), 64'(1));
        CFG_EN = 1'b0;
        repeat (5) tick();
        check("s1_idle", 64'(BUSY), 64'(0));
        check("s1_done_once", 64'(done_cnt), 64'(1));
        check("s1_no_late", 64'(late_cnt), 64'(0));

        // 4 KB page split: 0xFC0 leaves one beat in the page.
        do_reset();
        pop_always = 1'b1;
        start_frame(32'h0FC0, 16'h0040, 4, 1);
        wait_done("s2_frame_done", 1, 500);
        check("s2_ar_count", 64'(ar_cnt), 64'(2));
        check("s2_sb_empty", 64'(sb.size()), 64'(0));

        // Credit exhaustion: 64 credits allow four 16-beat bursts, 16 pops allow one more.
        do_reset();
        start_frame(32'h0, 16'h0400, 16, 8);
        repeat (60) tick();
        check("s3_ar_stall4", 64'(ar_cnt), 64'(4));
        check("s3_arvalid_low", 64'(M_ARVALID), 64'(0));
`ifdef HDMI_FETCH_PERF_EN
        check("s3_perf_nonzero", 64'(PERF_STALL != 32'd0), 64'(1));
`else
        check("s3_perf_zero", 64'(PERF_STALL), 64'(0));
`endif
        pops_left = 16;
        repeat (60) tick();
        check("s3_ar_after_pop", 64'(ar_cnt), 64'(5));
        check("s3_arvalid_low2", 64'(M_ARVALID), 64'(0));

        // ARREADY held off for 10 cycles, CFG_EN dropped at cycle 3.
        do_reset();
        pop_always = 1'b1;
        M_ARREADY  = 1'b0;
        start_frame(32'h0, 16'h0400, 16, 8);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) CFG_EN = 1'b0;
            tick();
        end
        check("s4_arvalid_held", 64'(M_ARVALID), 64'(1));
        check("s4_araddr_held", 64'(M_ARADDR), 64'(0));
        M_ARREADY = 1'b1;
        wait_idle("s4_idle", 200);
        check("s4_ar_count", 64'(ar_cnt), 64'(1));
        check("s4_no_frame_done", 64'(done_cnt), 64'(0));
        repeat (10) tick();
        check("s4_no_more_ar", 64'(ar_cnt), 64'(1));

        // Late VSYNC in the middle of a frame.
        do_reset();
        pop_always = 1'b1;
        start_frame(32'h1000, 16'h1400, 80, 2);
        repeat (6) tick();
        VSYNC_START = 1'b1;
        tick();
        VSYNC_START = 1'b0;
        wait_done("s5_frame_done", 1, 2000);
        check("s5_late_once", 64'(late_cnt), 64'(1));
        check("s5_ar_count", 64'(ar_cnt), 64'(10));
        check("s5_sb_empty", 64'(sb.size()), 64'(0));

        // Reset with three bursts in flight, then a fresh frame must see full credits.
        do_reset();
        pop_always = 1'b1;
        resp_en    = 1'b0;
        start_frame(32'h0, 16'h0400, 16, 8);
        k = 0;
        while (ar_cnt < 3 && k < 100) begin
            tick();
            k++;
        end
        check("s6_three_out", 64'(ar_cnt), 64'(3));
        #2;
        nRST = 1'b0;
        #1;
        check("s6_async_arvalid", 64'(M_ARVALID), 64'(0));
        check("s6_async_araddr", 64'(M_ARADDR), 64'(0));
        check("s6_async_arlen", 64'(M_ARLEN), 64'(0));
        check("s6_async_busy", 64'(BUSY), 64'(0));
        check("s6_async_pulses", 64'({FRAME_DONE, LATE}), 64'(0));
        check("s6_async_perf", 64'(PERF_STALL), 64'(0));
        CFG_EN     = 1'b0;
        pop_always = 1'b0;
        resp_en    = 1'b1;
        clear_tracking();
        @(posedge ACLK);
        #1;
        nRST = 1'b1;
        start_frame(32'h0, 16'h0400, 16, 8);
        repeat (60) tick();
        check("s6_full_credits", 64'(ar_cnt), 64'(4));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
